// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   wb_src_e : round-robin pointer encoding (which source wins a tie)
//   WB_*_DEF : default geometry of the write-back path
package wb_arbiter_pkg;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    localparam int unsigned WB_WIDTH_DEF     = 16;
    localparam int unsigned WB_DEPTH_DEF     = 64;
    localparam int unsigned WB_BUF_DEPTH_DEF = 2;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Small per-source result FIFO holding {dest reg, data} entries.
//   push/push_reg/push_data : enqueue (ignored when full)
//   pop                     : dequeue head (ignored when empty)
//   head_reg/head_data      : current head entry
//   empty/count             : occupancy
//   chk_reg/match           : per-entry "valid and dest == chk_reg" vector
module wb_fifo #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned AW        = 6,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [AW-1:0]                push_reg,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [AW-1:0]                head_reg,
    output logic [WIDTH-1:0]             head_data,
    output logic                         empty,
    output logic [$clog2(BUF_DEPTH):0]   count,
    input  logic [AW-1:0]                chk_reg,
    output logic [BUF_DEPTH-1:0]         match
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0]    reg_q  [BUF_DEPTH];
    logic [WIDTH-1:0] data_q [BUF_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(BUF_DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_reg  = reg_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    // Pointers and occupancy; reset drops every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are qualified by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            reg_q[wr_ptr]  <= push_reg;
            data_q[wr_ptr] <= push_data;
        end
    end

    // Slot i is live when its distance from the head is below count.
    always_comb begin
        match = '0;
        for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            match[i] = ({1'b0, PW'(PW'(i) - rd_ptr)} < count) && (reg_q[i] == chk_reg);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: buffers ALU and MEM results in per-source
// FIFOs and drives the single regfile write port, round-robin, one write/cycle.
//   alu_* / mem_*            : valid/ready result inputs (dest reg + data)
//   we_1/write_reg1(_data)   : registered regfile write port
//   chk_reg/chk_hit          : combinational "write still in flight" query
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH     = WB_WIDTH_DEF,
    parameter int unsigned DEPTH     = WB_DEPTH_DEF,
    parameter int unsigned BUF_DEPTH = WB_BUF_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [$clog2(DEPTH)-1:0]   alu_reg,
    input  logic [WIDTH-1:0]           alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [$clog2(DEPTH)-1:0]   mem_reg,
    input  logic [WIDTH-1:0]           mem_data,
    output logic                       we_1,
    output logic [$clog2(DEPTH)-1:0]   write_reg1,
    output logic [WIDTH-1:0]           write_reg1_data,
    input  logic [$clog2(DEPTH)-1:0]   chk_reg,
    output logic                       chk_hit
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    logic [CW-1:0]        alu_count, mem_count;
    logic                 alu_empty, mem_empty;
    logic [AW-1:0]        alu_head_reg, mem_head_reg;
    logic [WIDTH-1:0]     alu_head_data, mem_head_data;
    logic [BUF_DEPTH-1:0] alu_match, mem_match;
    logic                 alu_push, mem_push;
    logic                 grant_alu, grant_mem;
    wb_src_e              rr_q, rr_d;

    // Ready reflects registered occupancy only: a same-cycle pop never frees a slot early.
    assign alu_ready = rst_n & (alu_count < CW'(BUF_DEPTH));
    assign mem_ready = rst_n & (mem_count < CW'(BUF_DEPTH));

    // Register 0 is hard-wired: handshake completes but nothing is queued.
    assign alu_push = alu_valid & alu_ready & (alu_reg != '0);
    assign mem_push = mem_valid & mem_ready & (mem_reg != '0);

    wb_fifo #(.WIDTH(WIDTH), .AW(AW), .BUF_DEPTH(BUF_DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (alu_push),
        .push_reg  (alu_reg),
        .push_data (alu_data),
        .pop       (grant_alu),
        .head_reg  (alu_head_reg),
        .head_data (alu_head_data),
        .empty     (alu_empty),
        .count     (alu_count),
        .chk_reg   (chk_reg),
        .match     (alu_match)
    );

    wb_fifo #(.WIDTH(WIDTH), .AW(AW), .BUF_DEPTH(BUF_DEPTH)) u_mem_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mem_push),
        .push_reg  (mem_reg),
        .push_data (mem_data),
        .pop       (grant_mem),
        .head_reg  (mem_head_reg),
        .head_data (mem_head_data),
        .empty     (mem_empty),
        .count     (mem_count),
        .chk_reg   (chk_reg),
        .match     (mem_match)
    );

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= SRC_ALU;
        else        rr_q <= rr_d;
    end

    // Grant: lone non-empty source wins; on a tie the pointer decides, then flips.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        rr_d      = rr_q;
        if (!alu_empty && (mem_empty || rr_q == SRC_ALU)) begin
            grant_alu = 1'b1;
            rr_d      = SRC_MEM;
        end else if (!mem_empty) begin
            grant_mem = 1'b1;
            rr_d      = SRC_ALU;
        end
    end

    // Regfile write port; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_1            <= 1'b0;
            write_reg1      <= '0;
            write_reg1_data <= '0;
        end else begin
            we_1 <= grant_alu | grant_mem;
            if (grant_alu) begin
                write_reg1      <= alu_head_reg;
                write_reg1_data <= alu_head_data;
            end else if (grant_mem) begin
                write_reg1      <= mem_head_reg;
                write_reg1_data <= mem_head_data;
            end
        end
    end

    // In-flight means queued in either FIFO or on the write port this cycle.
    assign chk_hit = (chk_reg != '0)
                   & ((|alu_match) | (|mem_match) | (we_1 & (write_reg1 == chk_reg)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table plus hand-written sequences
// for interleaving, backpressure and mid-burst reset.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [5:0]  alu_reg, mem_reg, chk_reg, write_reg1;
    logic [15:0] alu_data, mem_data, write_reg1_data;
    logic        we_1, chk_hit;

    int tests = 0;
    int fails = 0;

    wb_arbiter #(.WIDTH(16), .DEPTH(64), .BUF_DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_reg         (alu_reg),
        .alu_data        (alu_data),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_reg         (mem_reg),
        .mem_data        (mem_data),
        .we_1            (we_1),
        .write_reg1      (write_reg1),
        .write_reg1_data (write_reg1_data),
        .chk_reg         (chk_reg),
        .chk_hit         (chk_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [5:0]  ar;
        logic [15:0] ad;
        logic        mv;
        logic [5:0]  mr;
        logic [15:0] md;
        logic [5:0]  chk;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [5:0]  e_wr;
        logic [15:0] e_wd;
        logic        e_hit;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic av, logic [5:0] ar, logic [15:0] ad,
                                logic mv, logic [5:0] mr, logic [15:0] md,
                                logic [5:0] chk, logic e_ar, logic e_mr, logic e_we,
                                logic [5:0] e_wr, logic [15:0] e_wd, logic e_hit);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md; v.chk = chk;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_we = e_we; v.e_wr = e_wr; v.e_wd = e_wd;
        v.e_hit = e_hit;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int            ai, mi, extra;
    bit            saw_af, saw_mf;
    logic [21:0]   wq[$];
    logic [21:0]   exp_w;
    logic [5:0]    er;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with a valid ALU request
        rst_n = 1'b0;
        idle_inputs();
        chk_reg   = '0;
        alu_valid = 1'b1; alu_reg = 6'd5; alu_data = 16'h5555;
        repeat (2) @(negedge clk);
        #1;
        check("rst_alu_ready", alu_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_we", we_1, 0);
        check("rst_wr", write_reg1, 0);
        check("rst_wd", write_reg1_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();

        // av  ar   ad          mv  mr   md           chk   ear emr ewe ewr  ewd       ehit
        vecs.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    0,    1, 1, 0, 0, 16'h0,    0));
        vecs.push_back(mk(1, 5, 16'h1234, 0, 0, 16'h0,    5,    1, 1, 0, 0, 16'h0,    0));
        vecs.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    5,    1, 1, 0, 0, 16'h0,    1));
        vecs.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    5,    1, 1, 1, 5, 16'h1234, 1));
        vecs.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    5,    1, 1, 0, 5, 16'h1234, 0));
        vecs.push_back(mk(0, 0, 16'h0,    1, 0, 16'hFFFF, 0,    1, 1, 0, 5, 16'h1234, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 16'h0, 0, 0, 16'h0,   0,    1, 1, 0, 5, 16'h1234, 0));
        vecs.push_back(mk(1, 7, 16'h0777, 0, 0, 16'h0,    7,    1, 1, 0, 5, 16'h1234, 0));
        vecs.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    7,    1, 1, 0, 5, 16'h1234, 1));
        vecs.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    7,    1, 1, 1, 7, 16'h0777, 1));
        vecs.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    7,    1, 1, 0, 7, 16'h0777, 0));
        vecs.push_back(mk(1, 3, 16'h0333, 1, 4, 16'h0444, 0,    1, 1, 0, 7, 16'h0777, 0));
        vecs.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    4,    1, 1, 0, 7, 16'h0777, 1));
        vecs.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    4,    1, 1, 1, 4, 16'h0444, 1));
        vecs.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    4,    1, 1, 1, 3, 16'h0333, 0));
        vecs.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    3,    1, 1, 0, 3, 16'h0333, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            alu_valid = vecs[i].av; alu_reg = vecs[i].ar; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_reg = vecs[i].mr; mem_data = vecs[i].md;
            chk_reg   = vecs[i].chk;
            #1;
            check($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].e_ar);
            check($sformatf("v%0d_mem_ready", i), mem_ready, vecs[i].e_mr);
            check($sformatf("v%0d_we", i), we_1, vecs[i].e_we);
            check($sformatf("v%0d_wr", i), write_reg1, vecs[i].e_wr);
            check($sformatf("v%0d_wd", i), write_reg1_data, vecs[i].e_wd);
            check($sformatf("v%0d_hit", i), chk_hit, vecs[i].e_hit);
        end

        // Both sources streaming from reset: strict alternation, ALU first
        do_reset();
        chk_reg = '0;
        ai = 0; mi = 0; saw_af = 0; saw_mf = 0;
        wq.delete();
        for (int c = 0; c < 40 && wq.size() < 8; c++) begin
            @(negedge clk);
            alu_valid = (ai < 4); alu_reg = 6'(ai + 1); alu_data = 16'hA000 | 16'(ai + 1);
            mem_valid = (mi < 4); mem_reg = 6'(mi + 9); mem_data = 16'hB000 | 16'(mi + 9);
            #1;
            if (we_1) wq.push_back({write_reg1, write_reg1_data});
            if (alu_valid && !alu_ready) saw_af = 1;
            if (mem_valid && !mem_ready) saw_mf = 1;
            if (alu_valid && alu_ready) ai++;
            if (mem_valid && mem_ready) mi++;
        end
        check("rr_write_count", 32'(wq.size()), 8);
        check("rr_alu_backpressure", saw_af, 1);
        check("rr_mem_backpressure", saw_mf, 1);
        for (int i = 0; i < 8; i++) begin
            er    = (i % 2 == 0) ? 6'(i / 2 + 1) : 6'(i / 2 + 9);
            exp_w = {er, ((i % 2 == 0) ? 16'hA000 : 16'hB000) | 16'(er)};
            check($sformatf("rr_order%0d", i), (i < wq.size()) ? 32'(wq[i]) : 32'hDEAD, 32'(exp_w));
        end
        idle_inputs();
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (we_1) extra++;
        end
        check("rr_no_duplicate", extra, 0);

        // Reset in the middle of a burst
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            alu_valid = 1'b1; alu_reg = 6'd20; alu_data = 16'h1111;
            mem_valid = 1'b1; mem_reg = 6'd21; mem_data = 16'h2222;
        end
        #1;
        check("burst_we_active", we_1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_we", we_1, 0);
        check("midrst_wr", write_reg1, 0);
        check("midrst_alu_ready", alu_ready, 0);
        check("midrst_mem_ready", mem_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        chk_reg = 6'd20;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (we_1) extra++;
        end
        check("midrst_no_stale", extra, 0);
        check("midrst_hit_clear", chk_hit, 0);
        check("midrst_alu_ready_back", alu_ready, 1);
        check("midrst_mem_ready_back", mem_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
